// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the RAW hazard scoreboard: entry field layout,
// the register-file bypass code and a width helper.
package hazard_scoreboard_pkg;

  // Each tracked entry is packed as {dst, ld, v}; dst occupies REG_W bits from ENT_DST.
  localparam int ENT_V   = 0;
  localparam int ENT_LD  = 1;
  localparam int ENT_DST = 2;

  // Bypass select value meaning "take the operand from the register file".
  localparam int SEL_REGFILE = 0;

  // Number of bits needed to encode 'value' distinct codes (ceil(log2(value))).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hazard_match_prio.sv
// Priority encoder over the per-entry match bits; the lowest (youngest)
// matching entry wins.
module hazard_match_prio #(
  parameter int DEPTH = 3,
  parameter int IDX_W = 2
) (
  input  logic [DEPTH-1:0] match_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o,
  output logic [DEPTH-1:0] onehot_o
);

  // Scan from oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    found_o  = 1'b0;
    idx_o    = '0;
    onehot_o = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (match_i[k]) begin
        found_o  = 1'b1;
        idx_o    = IDX_W'(k);
        onehot_o = '0;
        onehot_o[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW hazard detection and bypass selection over a DEPTH-entry shift table
// of in-flight destinations (entry 0 = execute, higher = older).
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 3,
  parameter int RDY_ALU  = 1,
  parameter int RDY_LOAD = 2,
  parameter int SEL_W    = clog2(DEPTH + 1)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    adv,
  input  logic                    flush,
  input  logic                    dec_valid,
  input  logic [REG_W-1:0]        dec_rs,
  input  logic [REG_W-1:0]        dec_rt,
  input  logic                    dec_read_rs,
  input  logic                    dec_read_rt,
  input  logic                    dec_wr_en,
  input  logic [REG_W-1:0]        dec_dst,
  input  logic                    dec_is_load,
  input  logic [DEPTH*DATA_W-1:0] stage_data,
  input  logic [DATA_W-1:0]       rf_rs_data,
  input  logic [DATA_W-1:0]       rf_rt_data,
  output logic                    raw_stall,
  output logic [SEL_W-1:0]        fwd_sel_rs,
  output logic [SEL_W-1:0]        fwd_sel_rt,
  output logic [DATA_W-1:0]       fwd_rs_data,
  output logic [DATA_W-1:0]       fwd_rt_data,
  output logic [31:0]             stall_cycles
);

  localparam int ENT_W = REG_W + 2;

  logic [ENT_W-1:0] ent_q [DEPTH];
  logic [ENT_W-1:0] ent_d [DEPTH];
  logic [31:0]      stall_cycles_q, stall_cycles_d;

  logic [DEPTH-1:0] ready, match_rs, match_rt, hot_rs, hot_rt;
  logic             found_rs, found_rt;
  logic [SEL_W-1:0] idx_rs, idx_rt;

  // Per-entry readiness by result class, and raw source-vs-destination matches.
  always_comb begin
    ready    = '0;
    match_rs = '0;
    match_rt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      ready[k]    = ent_q[k][ENT_LD] ? (k >= RDY_LOAD) : (k >= RDY_ALU);
      match_rs[k] = ent_q[k][ENT_V] & dec_read_rs &
                    (ent_q[k][ENT_DST +: REG_W] == dec_rs) & (dec_rs != '0);
      match_rt[k] = ent_q[k][ENT_V] & dec_read_rt &
                    (ent_q[k][ENT_DST +: REG_W] == dec_rt) & (dec_rt != '0);
    end
  end

  hazard_match_prio #(.DEPTH(DEPTH), .IDX_W(SEL_W)) u_prio_rs (
    .match_i  (match_rs),
    .found_o  (found_rs),
    .idx_o    (idx_rs),
    .onehot_o (hot_rs)
  );

  hazard_match_prio #(.DEPTH(DEPTH), .IDX_W(SEL_W)) u_prio_rt (
    .match_i  (match_rt),
    .found_o  (found_rt),
    .idx_o    (idx_rt),
    .onehot_o (hot_rt)
  );

  // Stall when either winning producer is not yet forwardable; flush overrides.
  always_comb begin
    raw_stall = dec_valid & ~flush & ((|(hot_rs & ~ready)) | (|(hot_rt & ~ready)));
  end

  // Bypass selects report the winner even while stalling; data follows the select.
  always_comb begin
    fwd_sel_rs  = found_rs ? (idx_rs + SEL_W'(1)) : SEL_W'(SEL_REGFILE);
    fwd_sel_rt  = found_rt ? (idx_rt + SEL_W'(1)) : SEL_W'(SEL_REGFILE);
    fwd_rs_data = rf_rs_data;
    fwd_rt_data = rf_rt_data;
    for (int k = 0; k < DEPTH; k++) begin
      if (hot_rs[k]) fwd_rs_data = stage_data[k*DATA_W +: DATA_W];
      if (hot_rt[k]) fwd_rt_data = stage_data[k*DATA_W +: DATA_W];
    end
  end

  // Next table state: shift on advance, inserting decode (or a bubble) at entry 0.
  always_comb begin
    ent_d          = ent_q;
    stall_cycles_d = stall_cycles_q;
    if (adv) begin
      for (int k = 1; k < DEPTH; k++) ent_d[k] = ent_q[k-1];
      ent_d[0] = '0;
      ent_d[0][ENT_V]  = dec_valid & dec_wr_en & (dec_dst != '0) & ~raw_stall & ~flush;
      ent_d[0][ENT_LD] = dec_is_load;
      ent_d[0][ENT_DST +: REG_W] = dec_dst;
      if (raw_stall && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  // Table and stall counter registers; reset discards everything in flight.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int k = 0; k < DEPTH; k++) ent_q[k] <= '0;
      stall_cycles_q <= '0;
    end else begin
      ent_q          <= ent_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard-style bench for hazard_scoreboard with three builds:
// inst 0 = defaults, inst 1 = RDY_ALU=0, inst 2 = DEPTH=5/RDY_LOAD=4.
module tb_hazard_scoreboard;

  logic         clock = 1'b0;
  logic         reset_n, adv, flush, decValid, decReadRs, decReadRt, decWrEn, decIsLoad;
  logic [4:0]   decRs, decRt, decDst;
  logic [159:0] stageData;
  logic [31:0]  rfRs, rfRt;
  logic [31:0]  stageVal [5];

  logic         stallA, stallB, stallC;
  logic [1:0]   selRsA, selRtA, selRsB, selRtB;
  logic [2:0]   selRsC, selRtC;
  logic [31:0]  dataRsA, dataRtA, dataRsB, dataRtB, dataRsC, dataRtC;
  logic [31:0]  cntA, cntB, cntC;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    int         inst;
    logic       rstN, adv, flush, valid, rdRs, rdRt, wr, ld;
    logic [4:0] rs, rt, dst;
    int         expStall, expSelRs, expSelRt, expCnt;
  } step_t;

  typedef struct {
    string        name;
    int           inst;
    logic [104:0] vec;
  } exp_t;

  exp_t sbQ[$];

  always #5 clock = ~clock;

  hazard_scoreboard dutA (
    .clock(clock), .reset_n(reset_n), .adv(adv), .flush(flush), .dec_valid(decValid),
    .dec_rs(decRs), .dec_rt(decRt), .dec_read_rs(decReadRs), .dec_read_rt(decReadRt),
    .dec_wr_en(decWrEn), .dec_dst(decDst), .dec_is_load(decIsLoad),
    .stage_data(stageData[95:0]), .rf_rs_data(rfRs), .rf_rt_data(rfRt),
    .raw_stall(stallA), .fwd_sel_rs(selRsA), .fwd_sel_rt(selRtA),
    .fwd_rs_data(dataRsA), .fwd_rt_data(dataRtA), .stall_cycles(cntA)
  );

  hazard_scoreboard #(.RDY_ALU(0)) dutB (
    .clock(clock), .reset_n(reset_n), .adv(adv), .flush(flush), .dec_valid(decValid),
    .dec_rs(decRs), .dec_rt(decRt), .dec_read_rs(decReadRs), .dec_read_rt(decReadRt),
    .dec_wr_en(decWrEn), .dec_dst(decDst), .dec_is_load(decIsLoad),
    .stage_data(stageData[95:0]), .rf_rs_data(rfRs), .rf_rt_data(rfRt),
    .raw_stall(stallB), .fwd_sel_rs(selRsB), .fwd_sel_rt(selRtB),
    .fwd_rs_data(dataRsB), .fwd_rt_data(dataRtB), .stall_cycles(cntB)
  );

  hazard_scoreboard #(.DEPTH(5), .RDY_LOAD(4)) dutC (
    .clock(clock), .reset_n(reset_n), .adv(adv), .flush(flush), .dec_valid(decValid),
    .dec_rs(decRs), .dec_rt(decRt), .dec_read_rs(decReadRs), .dec_read_rt(decReadRt),
    .dec_wr_en(decWrEn), .dec_dst(decDst), .dec_is_load(decIsLoad),
    .stage_data(stageData), .rf_rs_data(rfRs), .rf_rt_data(rfRt),
    .raw_stall(stallC), .fwd_sel_rs(selRsC), .fwd_sel_rt(selRtC),
    .fwd_rs_data(dataRsC), .fwd_rt_data(dataRtC), .stall_cycles(cntC)
  );

  // Build one stimulus step together with its expected outputs.
  function automatic step_t st(input string name, input int inst, input int rstN, input int a,
                               input int fl, input int v, input int rs, input int rdRs,
                               input int rt, input int rdRt, input int wr, input int dst,
                               input int ld, input int eStall, input int eSelRs,
                               input int eSelRt, input int eCnt);
    step_t s;
    s.name = name;          s.inst = inst;
    s.rstN = rstN[0];       s.adv = a[0];         s.flush = fl[0];   s.valid = v[0];
    s.rs = 5'(rs);          s.rdRs = rdRs[0];     s.rt = 5'(rt);     s.rdRt = rdRt[0];
    s.wr = wr[0];           s.dst = 5'(dst);      s.ld = ld[0];
    s.expStall = eStall;    s.expSelRs = eSelRs;  s.expSelRt = eSelRt; s.expCnt = eCnt;
    return s;
  endfunction

  // Expected output vector; data is derived from the expected select.
  function automatic logic [104:0] expVec(input int stall, input int selRs, input int selRt,
                                          input int cnt);
    logic [31:0] dRs, dRt;
    dRs = (selRs == 0) ? rfRs : stageVal[selRs-1];
    dRt = (selRt == 0) ? rfRt : stageVal[selRt-1];
    return {stall[0], 4'(selRs), 4'(selRt), dRs, dRt, 32'(cnt)};
  endfunction

  // Observed output vector of the chosen instance.
  function automatic logic [104:0] obsVec(input int inst);
    case (inst)
      0:       return {stallA, 2'b00, selRsA, 2'b00, selRtA, dataRsA, dataRtA, cntA};
      1:       return {stallB, 2'b00, selRsB, 2'b00, selRtB, dataRsB, dataRtB, cntB};
      default: return {stallC, 1'b0, selRsC, 1'b0, selRtC, dataRsC, dataRtC, cntC};
    endcase
  endfunction

  // Drive one step's inputs and push its expectation to the scoreboard.
  task automatic applyStimulus(input step_t s);
    exp_t e;
    reset_n = s.rstN; adv = s.adv; flush = s.flush; decValid = s.valid;
    decRs = s.rs; decReadRs = s.rdRs; decRt = s.rt; decReadRt = s.rdRt;
    decWrEn = s.wr; decDst = s.dst; decIsLoad = s.ld;
    e.name = s.name;
    e.inst = s.inst;
    e.vec  = expVec(s.expStall, s.expSelRs, s.expSelRt, s.expCnt);
    sbQ.push_back(e);
  endtask

  // One clock of synchronous reset with idle decode.
  task automatic applyReset();
    reset_n = 1'b0; adv = 1'b1; flush = 1'b0; decValid = 1'b0;
    decRs = '0; decRt = '0; decReadRs = 1'b0; decReadRt = 1'b0;
    decWrEn = 1'b0; decDst = '0; decIsLoad = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset_state();
    step_t s[$];
    exp_t e;
    logic [104:0] obs;
    applyReset();
    s.push_back(st("reset_idle_A", 0, 1,1,0, 1, 3,1, 4,1, 0,0,0, 0,0,0,0));
    s.push_back(st("reset_idle_C", 2, 1,1,0, 1, 5,1, 6,1, 0,0,0, 0,0,0,0));
    foreach (s[i]) begin
      applyStimulus(s[i]);
      #2;
      e = sbQ.pop_front();
      obs = obsVec(e.inst);
      checks++;
      if (obs !== e.vec) begin
        errors++;
        $display("[TB] FAIL %s got %h expected %h", e.name, obs, e.vec);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_alu_chain();
    step_t s[$];
    exp_t e;
    logic [104:0] obs;
    applyReset();
    s.push_back(st("alu_w_r3",      0, 1,1,0, 1, 0,0, 0,0, 1,3,0, 0,0,0,0));
    s.push_back(st("alu_dep_stall", 0, 1,1,0, 1, 3,1, 0,0, 1,4,0, 1,1,0,0));
    s.push_back(st("alu_dep_fwd",   0, 1,1,0, 1, 3,1, 0,0, 1,4,0, 0,2,0,1));
    s.push_back(st("alu_idle",      0, 1,1,0, 0, 0,0, 0,0, 0,0,0, 0,0,0,1));
    foreach (s[i]) begin
      applyStimulus(s[i]);
      #2;
      e = sbQ.pop_front();
      obs = obsVec(e.inst);
      checks++;
      if (obs !== e.vec) begin
        errors++;
        $display("[TB] FAIL %s got %h expected %h", e.name, obs, e.vec);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_load_use();
    step_t s[$];
    exp_t e;
    logic [104:0] obs;
    applyReset();
    s.push_back(st("ld_w_r5",       0, 1,1,0, 1, 0,0, 0,0, 1,5,1, 0,0,0,0));
    s.push_back(st("ld_use_stall1", 0, 1,1,0, 1, 5,1, 0,0, 1,6,0, 1,1,0,0));
    s.push_back(st("ld_use_stall2", 0, 1,1,0, 1, 5,1, 0,0, 1,6,0, 1,2,0,1));
    s.push_back(st("ld_use_fwd",    0, 1,1,0, 1, 5,1, 0,0, 1,6,0, 0,3,0,2));
    foreach (s[i]) begin
      applyStimulus(s[i]);
      #2;
      e = sbQ.pop_front();
      obs = obsVec(e.inst);
      checks++;
      if (obs !== e.vec) begin
        errors++;
        $display("[TB] FAIL %s got %h expected %h", e.name, obs, e.vec);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_priority();
    step_t s[$];
    exp_t e;
    logic [104:0] obs;
    applyReset();
    s.push_back(st("prio_w_r7a", 1, 1,1,0, 1, 0,0, 0,0, 1,7,0, 0,0,0,0));
    s.push_back(st("prio_w_r8",  1, 1,1,0, 1, 0,0, 0,0, 1,8,0, 0,0,0,0));
    s.push_back(st("prio_w_r7b", 1, 1,1,0, 1, 0,0, 0,0, 1,7,0, 0,0,0,0));
    s.push_back(st("prio_rd_r7", 1, 1,1,0, 1, 7,0, 7,1, 0,0,0, 0,0,1,0));
    foreach (s[i]) begin
      applyStimulus(s[i]);
      #2;
      e = sbQ.pop_front();
      obs = obsVec(e.inst);
      checks++;
      if (obs !== e.vec) begin
        errors++;
        $display("[TB] FAIL %s got %h expected %h", e.name, obs, e.vec);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_zero_and_hold();
    step_t s[$];
    exp_t e;
    logic [104:0] obs;
    applyReset();
    s.push_back(st("zero_w_r0",  0, 1,1,0, 1, 0,0, 0,0, 1,0,0, 0,0,0,0));
    s.push_back(st("zero_rd_r0", 0, 1,1,0, 1, 0,1, 0,1, 0,0,0, 0,0,0,0));
    s.push_back(st("hold_ld_r5", 0, 1,1,0, 1, 0,0, 0,0, 1,5,1, 0,0,0,0));
    for (int k = 0; k < 5; k++)
      s.push_back(st($sformatf("hold_frozen%0d", k), 0, 1,0,0, 1, 5,1, 0,0, 1,6,0, 1,1,0,0));
    s.push_back(st("hold_release", 0, 1,1,0, 1, 5,1, 0,0, 1,6,0, 1,1,0,0));
    s.push_back(st("hold_stall2",  0, 1,1,0, 1, 5,1, 0,0, 1,6,0, 1,2,0,1));
    s.push_back(st("hold_fwd",     0, 1,1,0, 1, 5,1, 0,0, 1,6,0, 0,3,0,2));
    foreach (s[i]) begin
      applyStimulus(s[i]);
      #2;
      e = sbQ.pop_front();
      obs = obsVec(e.inst);
      checks++;
      if (obs !== e.vec) begin
        errors++;
        $display("[TB] FAIL %s got %h expected %h", e.name, obs, e.vec);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_flush();
    step_t s[$];
    exp_t e;
    logic [104:0] obs;
    applyReset();
    s.push_back(st("fl_w_r10",       0, 1,1,0, 1, 0,0,  0,0, 1,10,0, 0,0,0,0));
    s.push_back(st("fl_dep_flushed", 0, 1,1,1, 1, 10,1, 0,0, 1,9,0,  0,1,0,0));
    s.push_back(st("fl_after",       0, 1,1,0, 1, 9,1, 10,1, 0,0,0,  0,0,2,0));
    foreach (s[i]) begin
      applyStimulus(s[i]);
      #2;
      e = sbQ.pop_front();
      obs = obsVec(e.inst);
      checks++;
      if (obs !== e.vec) begin
        errors++;
        $display("[TB] FAIL %s got %h expected %h", e.name, obs, e.vec);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_midrun_reset();
    step_t s[$];
    exp_t e;
    logic [104:0] obs;
    applyReset();
    s.push_back(st("rst_ld_r20",    0, 1,1,0, 1, 0,0,  0,0,  1,20,1, 0,0,0,0));
    s.push_back(st("rst_use_stall", 0, 1,1,0, 1, 20,1, 0,0,  0,0,0,  1,1,0,0));
    s.push_back(st("rst_bubble",    0, 1,1,0, 0, 0,0,  0,0,  0,0,0,  0,0,0,1));
    s.push_back(st("rst_w_r11",     0, 1,1,0, 1, 0,0,  0,0,  1,11,0, 0,0,0,1));
    s.push_back(st("rst_w_r12",     0, 1,1,0, 1, 0,0,  0,0,  1,12,0, 0,0,0,1));
    s.push_back(st("rst_w_r13",     0, 1,1,0, 1, 0,0,  0,0,  1,13,0, 0,0,0,1));
    s.push_back(st("rst_pre",       0, 1,0,0, 1, 13,1, 11,1, 0,0,0,  1,1,3,1));
    s.push_back(st("rst_assert",    0, 0,0,0, 1, 13,1, 11,1, 0,0,0,  1,1,3,1));
    s.push_back(st("rst_after",     0, 1,0,0, 1, 13,1, 11,1, 0,0,0,  0,0,0,0));
    foreach (s[i]) begin
      applyStimulus(s[i]);
      #2;
      e = sbQ.pop_front();
      obs = obsVec(e.inst);
      checks++;
      if (obs !== e.vec) begin
        errors++;
        $display("[TB] FAIL %s got %h expected %h", e.name, obs, e.vec);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_deep_load();
    step_t s[$];
    exp_t e;
    logic [104:0] obs;
    applyReset();
    s.push_back(st("deep_ld_r5", 2, 1,1,0, 1, 0,0, 0,0, 1,5,1, 0,0,0,0));
    for (int k = 1; k <= 4; k++)
      s.push_back(st($sformatf("deep_stall%0d", k), 2, 1,1,0, 1, 5,1, 0,0, 1,6,0, 1,k,0,k-1));
    s.push_back(st("deep_fwd", 2, 1,1,0, 1, 5,1, 0,0, 1,6,0, 0,5,0,4));
    foreach (s[i]) begin
      applyStimulus(s[i]);
      #2;
      e = sbQ.pop_front();
      obs = obsVec(e.inst);
      checks++;
      if (obs !== e.vec) begin
        errors++;
        $display("[TB] FAIL %s got %h expected %h", e.name, obs, e.vec);
      end
      @(negedge clock);
    end
  endtask

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    stageVal[0] = 32'h11110000;
    stageVal[1] = 32'h0000002A;
    stageVal[2] = 32'hDEADBEEF;
    stageVal[3] = 32'h33333333;
    stageVal[4] = 32'h44444444;
    stageData = {stageVal[4], stageVal[3], stageVal[2], stageVal[1], stageVal[0]};
    rfRs = 32'hAAAA0001;
    rfRt = 32'hBBBB0002;
    reset_n = 1'b0; adv = 1'b1; flush = 1'b0; decValid = 1'b0;
    decRs = '0; decRt = '0; decReadRs = 1'b0; decReadRt = 1'b0;
    decWrEn = 1'b0; decDst = '0; decIsLoad = 1'b0;
    @(negedge clock);
    test_reset_state();
    test_alu_chain();
    test_load_use();
    test_priority();
    test_zero_and_hold();
    test_flush();
    test_midrun_reset();
    test_deep_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
